// File: rtl/key_step_ctrl.sv
// Step/run key controller: turns debounced key levels into a CPU clock enable,
// with single-step pulses, hold-to-repeat and a free-run toggle.
module key_step_ctrl #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_BITS      = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_key,
    input  logic        run_key,
    output logic        cpu_en,
    output logic        step_pulse,
    output logic        run_mode,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] HOLD_LAST   = CNT_BITS'(HOLD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);

    state_t              state_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic                step_d_reg;
    logic                run_d_reg;
    logic                run_mode_reg;
    logic                step_pulse_reg;
    logic [15:0]         step_count_reg;

    logic rise_s;
    logic rise_r;
    logic fire_next;

    // A run edge wins over everything; in run mode no step pulses are issued.
    always_comb begin
        rise_s    = step_key & ~step_d_reg;
        rise_r    = run_key & ~run_d_reg;
        fire_next = 1'b0;
        if (!rise_r && !run_mode_reg) begin
            case (state_reg)
                IDLE:    fire_next = rise_s;
                HELD:    fire_next = step_key && (cnt_reg == HOLD_LAST);
                REPEAT:  fire_next = step_key && (cnt_reg == REPEAT_LAST);
                default: fire_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            step_d_reg     <= 1'b1;
            run_d_reg      <= 1'b1;
            run_mode_reg   <= 1'b0;
            step_pulse_reg <= 1'b0;
            step_count_reg <= '0;
        end else begin
            step_d_reg     <= step_key;
            run_d_reg      <= run_key;
            step_pulse_reg <= fire_next;
            step_count_reg <= step_count_reg + {15'd0, fire_next};

            if (rise_r) begin
                run_mode_reg <= ~run_mode_reg;
                state_reg    <= IDLE;
                cnt_reg      <= '0;
            end else if (run_mode_reg) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise_s) begin
                            cnt_reg   <= '0;
                            state_reg <= HELD;
                        end
                    end
                    HELD: begin
                        if (!step_key) begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else if (cnt_reg == HOLD_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= REPEAT;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_BITS'(1);
                        end
                    end
                    REPEAT: begin
                        if (!step_key) begin
                            state_reg <= IDLE;
                        end else if (cnt_reg == REPEAT_LAST) begin
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_BITS'(1);
                        end
                    end
                    default: begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cpu_en     = run_mode_reg | step_pulse_reg;
    assign step_pulse = step_pulse_reg;
    assign run_mode   = run_mode_reg;
    assign step_count = step_count_reg;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Bench for key_step_ctrl: two instances (8/4 and 1/1 timing) share stimulus and are
// compared every cycle against a press-age model; directed scenarios plus random keys.
module tb_key_step_ctrl;

    logic        clk;
    logic        rst;
    logic        step_key;
    logic        run_key;
    logic        cpu_en_a, step_pulse_a, run_mode_a;
    logic [15:0] step_count_a;
    logic        cpu_en_b, step_pulse_b, run_mode_b;
    logic [15:0] step_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    key_step_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .step_key(step_key), .run_key(run_key),
        .cpu_en(cpu_en_a), .step_pulse(step_pulse_a), .run_mode(run_mode_a),
        .step_count(step_count_a)
    );

    key_step_ctrl #(.HOLD_CYCLES(1), .REPEAT_CYCLES(1), .CNT_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .step_key(step_key), .run_key(run_key),
        .cpu_en(cpu_en_b), .step_pulse(step_pulse_b), .run_mode(run_mode_b),
        .step_count(step_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance tracks how many edges the current press has lasted.
    int          m_hold  [2] = '{8, 1};
    int          m_rep   [2] = '{4, 1};
    logic        m_prev_s[2];
    logic        m_prev_r[2];
    logic        m_run   [2];
    logic        m_active[2];
    int          m_age   [2];
    logic        m_pulse [2];
    logic [15:0] m_count [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input logic rs, input logic sk, input logic rk);
        m_pulse[i] = 1'b0;
        if (rs) begin
            m_prev_s[i] = 1'b1;
            m_prev_r[i] = 1'b1;
            m_run[i]    = 1'b0;
            m_active[i] = 1'b0;
            m_age[i]    = 0;
            m_count[i]  = 16'd0;
            return;
        end
        if (rk && !m_prev_r[i]) begin
            m_run[i]    = ~m_run[i];
            m_active[i] = 1'b0;
        end else if (m_run[i]) begin
            m_active[i] = 1'b0;
        end else if (m_active[i]) begin
            if (sk) begin
                m_age[i]++;
                if (m_age[i] == m_hold[i] ||
                    (m_age[i] > m_hold[i] && ((m_age[i] - m_hold[i]) % m_rep[i]) == 0))
                    m_pulse[i] = 1'b1;
            end else begin
                m_active[i] = 1'b0;
            end
        end else if (sk && !m_prev_s[i]) begin
            m_active[i] = 1'b1;
            m_age[i]    = 0;
            m_pulse[i]  = 1'b1;
        end
        if (m_pulse[i]) m_count[i] = m_count[i] + 16'd1;
        m_prev_s[i] = sk;
        m_prev_r[i] = rk;
    endtask

    task automatic tick(input logic rs, input logic sk, input logic rk);
        rst      = rs;
        step_key = sk;
        run_key  = rk;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, rs, sk, rk);
        #1;
        check("a_pulse", 32'(step_pulse_a), 32'(m_pulse[0]));
        check("a_run",   32'(run_mode_a),   32'(m_run[0]));
        check("a_cpu_en", 32'(cpu_en_a),    32'(m_run[0] | m_pulse[0]));
        check("a_count", 32'(step_count_a), 32'(m_count[0]));
        check("b_pulse", 32'(step_pulse_b), 32'(m_pulse[1]));
        check("b_run",   32'(run_mode_b),   32'(m_run[1]));
        check("b_cpu_en", 32'(cpu_en_b),    32'(m_run[1] | m_pulse[1]));
        check("b_count", 32'(step_count_b), 32'(m_count[1]));
    endtask

    initial begin
        logic [15:0] base;
        int          pulses;
        int          guard;
        logic        sk_r;
        rst = 1'b1; step_key = 1'b1; run_key = 1'b0;

        // Key held through reset release: no event.
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        check("rst_pulse", 32'(step_pulse_a), 32'd0);
        check("rst_cpu_en", 32'(cpu_en_a), 32'd0);
        check("rst_count", 32'(step_count_a), 32'd0);
        pulses = 0;
        repeat (4) begin
            tick(1'b0, 1'b1, 1'b0);
            pulses += int'(step_pulse_a);
        end
        check("held_thru_rst_pulses", 32'(pulses), 32'd0);
        $display("txn reset-with-key-held: count=%0d", step_count_a);

        // Short press: one pulse, on the first edge sampling the key high.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("short_first_edge", 32'(step_pulse_a), 32'd1);
        pulses = 1;
        repeat (2) begin
            tick(1'b0, 1'b1, 1'b0);
            pulses += int'(step_pulse_a);
        end
        tick(1'b0, 1'b0, 1'b0);
        pulses += int'(step_pulse_a);
        check("short_pulses", 32'(pulses), 32'd1);
        check("short_count", 32'(step_count_a), 32'd1);
        $display("txn short-press: count=%0d", step_count_a);

        // Hold for edges k..k+20: pulses at k, k+8, k+12, k+16, k+20.
        base = step_count_a;
        for (int e = 0; e <= 20; e++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (e == 0 || e == 8 || e == 12 || e == 16 || e == 20)
                check("hold_pulse_on", 32'(step_pulse_a), 32'd1);
            else
                check("hold_pulse_off", 32'(step_pulse_a), 32'd0);
        end
        repeat (6) begin
            tick(1'b0, 1'b0, 1'b0);
            check("after_release", 32'(step_pulse_a), 32'd0);
        end
        check("hold20_count", 32'(step_count_a - base), 32'd5);
        $display("txn hold-20: count=%0d", step_count_a);

        // Release on the edge where the counter would expire: no pulse.
        base = step_count_a;
        repeat (8) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("release_at_expiry", 32'(step_count_a - base), 32'd1);
        $display("txn release-at-expiry: count=%0d", step_count_a);

        // Run mode on, step presses ignored, run mode off.
        tick(1'b0, 1'b0, 1'b1);
        check("run_on", 32'(run_mode_a), 32'd1);
        base = step_count_a;
        for (int r = 0; r < 12; r++) begin
            tick(1'b0, r[1], 1'b0);
            check("run_cpu_en", 32'(cpu_en_a), 32'd1);
        end
        check("run_count_frozen", 32'(step_count_a), 32'(base));
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("run_off", 32'(run_mode_a), 32'd0);
        check("run_off_cpu_en", 32'(cpu_en_a), 32'd0);
        $display("txn run-toggle: run_mode=%0d", run_mode_a);

        // Simultaneous run and step rise from step mode.
        base = step_count_a;
        tick(1'b0, 1'b1, 1'b1);
        check("simul_run", 32'(run_mode_a), 32'd1);
        check("simul_pulse", 32'(step_pulse_a), 32'd0);
        check("simul_count", 32'(step_count_a), 32'(base));
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        $display("txn simultaneous-rise: count=%0d", step_count_a);

        // Wrap: the 1/1 instance pulses every cycle while held.
        tick(1'b0, 1'b0, 1'b0);
        guard = 0;
        while (m_count[1] != 16'hFFFF && guard < 70000) begin
            tick(1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("wrap_preload_bound", 32'(guard < 70000), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check("wrap_preload", 32'(step_count_b), 32'hFFFF);
        tick(1'b0, 1'b1, 1'b0);
        check("wrap_to_zero", 32'(step_count_b), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        $display("txn wrap: count_b=%0h", step_count_b);

        // Reset in the middle of a hold.
        tick(1'b0, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("midhold_rst_pulse", 32'(step_pulse_a), 32'd0);
        check("midhold_rst_cpu_en", 32'(cpu_en_a), 32'd0);
        check("midhold_rst_run", 32'(run_mode_a), 32'd0);
        check("midhold_rst_count", 32'(step_count_a), 32'd0);
        check("midhold_rst_count_b", 32'(step_count_b), 32'd0);
        $display("txn reset-mid-hold: count=%0d", step_count_a);

        // Randomized key activity, checked against the model every cycle.
        sk_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic rk_r, rs_r;
            if ($urandom_range(0, 7) == 0) sk_r = ~sk_r;
            rk_r = ($urandom_range(0, 29) == 0);
            rs_r = ($urandom_range(0, 499) == 0);
            tick(rs_r, sk_r, rk_r);
            if (c % 500 == 499)
                $display("txn random-block %0d: count_a=%0d count_b=%0d run=%0d",
                         c / 500, step_count_a, step_count_b, run_mode_a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
